// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multi-cycle RV64 control sequencer:
// opcode values, FSM state encodings and ALU operation codes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    FAULT     = 3'd7
  } ctrl_state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  // True for the opcodes that pass through the MEM state.
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Handshake wait counter. Counts cycles spent waiting on a ready input,
// clears whenever the sequencer changes state, and flags expiry on the
// last permitted wait cycle. TIMEOUT_CYCLES = 0 disables expiry.
module ctrl_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Wait-cycle counter: reset/clear to zero, otherwise count while enabled.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Expiry is only meaningful while still waiting; a ready in the same
  // cycle drops enable, so the handshake wins over the fault.
  assign expire = (TIMEOUT_CYCLES != 0) && enable && (count_r == LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the RV64 datapath. Steps each instruction
// through FETCH/DECODE/EXECUTE/MEM/WRITEBACK, drives datapath strobes and
// mux selects, resolves branches and faults on memory handshake timeout.
// Optional feature macro: PERF_COUNTERS_EN adds cycle_count and instret.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_flag,
  output logic        imem_req,
  output logic        ir_load,
  output logic        pc_load,
  output logic        pc_src,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        illegal,
  output logic        timeout,
  output logic [2:0]  state
`ifdef PERF_COUNTERS_EN
  ,
  output logic [63:0] cycle_count,
  output logic [63:0] instret
`endif
);

  ctrl_state_e state_r;
  ctrl_state_e next_s;
  logic [6:0]  opcode_r;
  logic        waiting_s;
  logic        expire_s;
  logic        clear_s;

  assign state = state_r;

  // Cycles that sit in FETCH/MEM without the matching ready count as waits.
  assign waiting_s = !reset &&
                     (((state_r == FETCH) && !imem_ready) ||
                      ((state_r == MEM)   && !dmem_ready));
  assign clear_s   = (next_s != state_r);

  ctrl_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .clear (clear_s),
    .enable(waiting_s),
    .expire(expire_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Opcode latch, loaded together with the instruction register.
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_r <= 7'd0;
    end else if (ir_load) begin
      opcode_r <= instruction[6:0];
    end else begin
      opcode_r <= opcode_r;
    end
  end

  // Next-state and datapath control; reset forces every strobe low.
  always_comb begin
    next_s     = state_r;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    pc_load    = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    timeout    = 1'b0;
    if (reset) begin
      next_s = FETCH;
    end else begin
      case (state_r)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_load = 1'b1;
            next_s  = DECODE;
          end else if (expire_s) begin
            next_s = FAULT;
          end else begin
            next_s = FETCH;
          end
        end
        DECODE: begin
          next_s = EXECUTE;
        end
        EXECUTE: begin
          case (opcode_r)
            OP_R: begin
              alu_src = 1'b0;
              alu_op  = ALU_FUNCT;
              next_s  = WRITEBACK;
            end
            OP_I: begin
              alu_src = 1'b1;
              alu_op  = ALU_FUNCT;
              next_s  = WRITEBACK;
            end
            OP_LOAD, OP_STORE: begin
              alu_src = 1'b1;
              alu_op  = ALU_ADD;
              next_s  = MEM;
            end
            OP_BRANCH: begin
              alu_op  = ALU_SUB;
              pc_load = 1'b1;
              pc_src  = branch_flag;
              next_s  = FETCH;
            end
            default: begin
              illegal = 1'b1;
              pc_load = 1'b1;
              pc_src  = 1'b0;
              next_s  = FETCH;
            end
          endcase
        end
        MEM: begin
          alu_src = 1'b1;
          alu_op  = ALU_ADD;
          if (opcode_r == OP_LOAD) begin
            mem_read = 1'b1;
          end else begin
            mem_write = 1'b1;
          end
          if (dmem_ready) begin
            if (opcode_r == OP_LOAD) begin
              next_s = WRITEBACK;
            end else begin
              pc_load = 1'b1;
              pc_src  = 1'b0;
              next_s  = FETCH;
            end
          end else if (expire_s) begin
            next_s = FAULT;
          end else begin
            next_s = MEM;
          end
        end
        WRITEBACK: begin
          reg_write  = 1'b1;
          mem_to_reg = (opcode_r == OP_LOAD);
          pc_load    = 1'b1;
          pc_src     = 1'b0;
          next_s     = FETCH;
        end
        FAULT: begin
          timeout = 1'b1;
          next_s  = FAULT;
        end
        default: begin
          next_s = FAULT;
        end
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  // Free-running cycle counter and retired-instruction counter; illegal
  // opcodes advance the PC but are not counted as retired.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= 64'd0;
      instret     <= 64'd0;
    end else begin
      cycle_count <= cycle_count + 64'd1;
      if (pc_load && !illegal) begin
        instret <= instret + 64'd1;
      end else begin
        instret <= instret;
      end
    end
  end
`endif

endmodule
